// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
// No logic here; latency and backpressure are defined by the modules that import it.
package ram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Round-robin grant between two requesters; combinational grant, pointer updated on transfer.
// Zero-cycle grant latency; grant is suppressed entirely when en is low.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic               gnt_idx
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant   = '0;
    gnt_idx = 1'b0;
    if (en) begin
      case (valid)
        2'b01: begin
          grant   = 2'b01;
          gnt_idx = 1'b0;
        end
        2'b10: begin
          grant   = 2'b10;
          gnt_idx = 1'b1;
        end
        2'b11: begin
          gnt_idx = ptr_q;
          grant   = ptr_q ? 2'b10 : 2'b01;
        end
        default: begin
          grant   = '0;
          gnt_idx = 1'b0;
        end
      endcase
    end
  end

  // A grant only issues to a valid requester, so any grant is a transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (|grant) begin
      ptr_d = ~gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between two requesters, with a full-memory clear sweep.
// Commands issue the same cycle they are granted; read data returns one cycle later with no backpressure.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] FILL       = DATA_WIDTH'(8'hFF)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  input  logic                          clr_req,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_wen,
  output logic                          mem_ren,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      rsp_pend_q, rsp_pend_d;

  logic                    arb_en;
  logic [NUM_REQ-1:0]      grant;
  logic                    gnt_idx;
  logic                    gnt_any;
  logic                    gnt_we;
  logic [ADDR_WIDTH-1:0]   gnt_addr;
  logic [DATA_WIDTH-1:0]   gnt_wdata;

  // clr_req wins over any pending command in the same cycle.
  assign arb_en = (state_q == SERVE) && !clr_req && !rst;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en),
    .valid   (req_valid),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );

  assign gnt_any   = |grant;
  assign gnt_we    = gnt_idx ? req_we[1] : req_we[0];
  assign gnt_addr  = gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign gnt_wdata = gnt_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SERVE;
      cnt_q      <= '0;
      rsp_pend_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_pend_q <= rsp_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rsp_pend_d = '0;
    case (state_q)
      SERVE: begin
        if (clr_req) begin
          state_d = CLEAR;
        end else if (gnt_any && !gnt_we) begin
          rsp_pend_d = grant;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = SERVE;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  // Every output is held quiet while rst is high, including an in-flight response.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    busy      = 1'b0;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_wdata = '0;
    if (!rst) begin
      rsp_valid = rsp_pend_q;
      if (|rsp_pend_q) begin
        rsp_rdata = mem_rdata;
      end
      case (state_q)
        SERVE: begin
          req_ready = grant;
          if (gnt_any) begin
            mem_addr  = gnt_addr;
            mem_wdata = gnt_wdata;
            mem_wen   = gnt_we;
            mem_ren   = ~gnt_we;
          end
        end
        CLEAR: begin
          busy      = 1'b1;
          mem_wen   = 1'b1;
          mem_addr  = cnt_q;
          mem_wdata = FILL;
        end
        default: busy = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM attached.
// Each vector drives inputs just after a rising edge and checks settled outputs before the next.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        clr_req;
  logic        busy;
  logic [3:0]  mem_addr;
  logic        mem_wen;
  logic        mem_ren;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  logic [7:0]  mem [16];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (8),
    .FILL       (8'hFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .clr_req   (clr_req),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Registered-read RAM model.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic clr);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    clr_req   = clr;
    #1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    rst = 1'b1;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0);
    next_cyc();

    // Reset state with commands pending.
    drive(2'b11, 2'b01, 4'd5, 4'd6, 8'h33, 8'h44, 1'b0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rspv", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_wen_ren", 32'({mem_wen, mem_ren}), 32'h0);
    chk("rst_addr_wdata", 32'({mem_addr, mem_wdata}), 32'h0);
    next_cyc();
    rst = 1'b0;

    // Write A5 to address 3, then read it back.
    drive(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00, 1'b0);
    chk("wr_ready", 32'(req_ready), 32'h1);
    chk("wr_mem", 32'({mem_wen, mem_ren, mem_addr, mem_wdata}), 32'h2_3A5);
    next_cyc();
    drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("rd_ready", 32'(req_ready), 32'h1);
    chk("rd_mem", 32'({mem_wen, mem_ren, mem_addr}), 32'h1_3);
    chk("rd_no_rsp", 32'(rsp_valid), 32'h0);
    next_cyc();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("rd_rspv", 32'(rsp_valid), 32'h1);
    chk("rd_rdata", 32'(rsp_rdata), 32'hA5);
    chk("idle_mem", 32'({mem_wen, mem_ren, req_ready}), 32'h0);
    next_cyc();

    // Lone req1 for three cycles, then pointer favours req0.
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 2'b00, 4'd0, 4'd5, 8'h00, 8'h00, 1'b0);
      chk("solo1_ready", 32'(req_ready), 32'h2);
      chk("solo1_rspv", 32'(rsp_valid), (i == 0) ? 32'h0 : 32'h2);
      next_cyc();
    end
    drive(2'b11, 2'b00, 4'd1, 4'd5, 8'h00, 8'h00, 1'b0);
    chk("ptr_after_solo", 32'(req_ready), 32'h1);
    chk("solo1_rdata", 32'(rsp_rdata), 32'h15);
    next_cyc();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("ptr_rsp", 32'({rsp_valid, rsp_rdata}), 32'h1_11);
    next_cyc();

    // Reset, then both read continuously: grants alternate.
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 1'b0);
      chk("alt_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i == 0) chk("alt_rspv0", 32'(rsp_valid), 32'h0);
      else chk("alt_rsp", 32'({rsp_valid, rsp_rdata}), (i % 2 == 1) ? 32'h1_11 : 32'h2_12);
      next_cyc();
    end
    // Reset while req1's read is outstanding.
    rst = 1'b1;
    drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 1'b0);
    chk("rst_kill_rsp", 32'({rsp_valid, req_ready}), 32'h0);
    next_cyc();
    rst = 1'b0;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("post_rst_rsp", 32'(rsp_valid), 32'h0);
    next_cyc();

    // Read, then clear pulse with both valid; second clr_req mid-sweep.
    drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 1'b0);
    chk("pre_clr_ready", 32'(req_ready), 32'h1);
    next_cyc();
    drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 1'b1);
    chk("clr_no_grant", 32'({req_ready, mem_wen, mem_ren, busy}), 32'h0);
    chk("clr_rsp_kept", 32'({rsp_valid, rsp_rdata}), 32'h1_11);
    next_cyc();
    for (int i = 0; i < 16; i++) begin
      drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, (i == 5));
      chk("swp_busy_ready", 32'({busy, req_ready}), 32'h4);
      chk("swp_mem", 32'({mem_wen, mem_ren, mem_addr, mem_wdata}), {20'h0, 2'b10, 4'(i), 8'hFF});
      if (i == 0) chk("swp_rspv", 32'(rsp_valid), 32'h0);
      next_cyc();
    end
    drive(2'b01, 2'b00, 4'd9, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("swp_end", 32'({busy, req_ready}), 32'h1);
    next_cyc();
    drive(2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00, 1'b0);
    chk("fill_rd9", 32'({rsp_valid, rsp_rdata}), 32'h1_FF);
    next_cyc();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("fill_rd3", 32'({rsp_valid, rsp_rdata}), 32'h2_FF);
    next_cyc();

    // Seed addresses 7..15, then reset at sweep address 7.
    for (int i = 7; i < 16; i++) begin
      drive(2'b01, 2'b01, 4'(i), 4'd0, 8'h40 + 8'(i), 8'h00, 1'b0);
      chk("seed_ready", 32'(req_ready), 32'h1);
      next_cyc();
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 1'b1);
    next_cyc();
    for (int i = 0; i < 7; i++) begin
      drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0);
      chk("part_swp", 32'({busy, mem_addr}), {27'h0, 1'b1, 4'(i)});
      next_cyc();
    end
    rst = 1'b1;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("abort_rst", 32'({busy, mem_wen}), 32'h0);
    next_cyc();
    rst = 1'b0;
    drive(2'b01, 2'b00, 4'd8, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("abort_serve", 32'({busy, req_ready}), 32'h1);
    next_cyc();
    drive(2'b01, 2'b00, 4'd15, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("keep_8", 32'({rsp_valid, rsp_rdata}), 32'h1_48);
    next_cyc();
    drive(2'b01, 2'b00, 4'd7, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("keep_15", 32'({rsp_valid, rsp_rdata}), 32'h1_4F);
    next_cyc();
    drive(2'b01, 2'b00, 4'd6, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("keep_7", 32'({rsp_valid, rsp_rdata}), 32'h1_47);
    next_cyc();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("cleared_6", 32'({rsp_valid, rsp_rdata}), 32'h1_FF);
    next_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, address width of the shared single-port memory.
REQ-002 Parameter DATA_WIDTH, default 8, data width of the shared memory.
REQ-003 Parameter FILL, default 8'hFF (DATA_WIDTH bits), value written by the clear sweep.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  2  per-requester command valid; bit i = requester i.
REQ-007 req_ready  output  2  per-requester grant; a command transfers when valid[i] & ready[i].
REQ-008 req_we  input  2  per-requester 1 = write, 0 = read.
REQ-009 req_addr  input  2*ADDR_WIDTH  requester i address in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 req_wdata  input  2*DATA_WIDTH  requester i write data, packed the same way.
REQ-011 rsp_valid  output  2  read data valid for requester i; single-cycle pulse, no backpressure.
REQ-012 rsp_rdata  output  DATA_WIDTH  read data, meaningful only when some rsp_valid bit is 1.
REQ-013 clr_req  input  1  start a full-memory clear sweep.
REQ-014 busy  output  1  1 while the clear sweep runs.
REQ-015 mem_addr, mem_wen, mem_ren, mem_wdata  outputs  ADDR_WIDTH/1/1/DATA_WIDTH  drive the memory port.
REQ-016 mem_rdata  input  DATA_WIDTH  memory read data, registered by the memory one cycle after mem_ren.

Function
REQ-017 FSM states SERVE and CLEAR; reset state SERVE.
REQ-018 SERVE: at most one bit of req_ready is high per cycle; it is high for the granted requester whenever that requester has req_valid high.
REQ-019 Arbitration is round-robin over 2 requesters; pointer holder wins when both are valid; after any transfer the pointer moves to the other requester; a lone valid requester is granted regardless of pointer.
REQ-020 Transfer cycle N drives mem_addr/mem_wdata/mem_wen/mem_ren combinationally from the granted command in the same cycle N; mem_wen = we, mem_ren = ~we.
REQ-021 A read transferred in cycle N asserts rsp_valid[i] in cycle N+1 with rsp_rdata = mem_rdata; back-to-back reads give back-to-back responses.
REQ-022 Writes produce no response; a write then a read of the same address in consecutive cycles returns the new data.
REQ-023 No transfer: mem_wen = mem_ren = 0.
REQ-024 clr_req high in SERVE moves to CLEAR next cycle; clr_req takes precedence, so no grant occurs in that cycle.
REQ-025 CLEAR: busy = 1, req_ready = 0, one write per cycle of FILL to addresses 0,1,...,2^ADDR_WIDTH-1 in order; exactly 2^ADDR_WIDTH busy cycles; returns to SERVE after the last address.
REQ-026 A read response due in the cycle CLEAR is entered is still delivered.
REQ-027 clr_req during CLEAR is ignored; the sweep does not restart.
REQ-028 The address counter wraps only at sweep end and returns to 0.

Reset
REQ-029 rst forces SERVE, pointer = requester 0, sweep counter = 0, busy = 0, rsp_valid = 0, rsp_rdata = 0, req_ready = 0, mem_wen = mem_ren = 0, mem_addr = 0, mem_wdata = 0, in the cycle rst is high.
REQ-030 rst mid-sweep abandons the sweep; it does not resume, and partially cleared contents are left as they are.
REQ-031 rst during an outstanding read suppresses that response.

Structure
REQ-032 Package ram_arb_pkg holds the state enum (SERVE, CLEAR) and the constant NUM_REQ = 2.
REQ-033 Sub-module rr_arb2 is the natural split: the round-robin pointer plus the grant logic. Everything else stays in ram_port_arbiter.

Verification
REQ-034 After reset, req0 writes 8'hA5 to address 3 and then reads address 3 -> rsp_valid = 2'b01 one cycle after the read transfer, with rsp_rdata = 8'hA5.
REQ-035 Both requesters read continuously from reset -> grants alternate 0,1,0,1; each rsp_valid bit pulses every other cycle.
REQ-036 Only req1 valid for 3 cycles -> three consecutive grants to req1; the pointer then favours req0.
REQ-037 clr_req pulse with both requesters valid -> no grant that cycle, busy high exactly 16 cycles, mem_addr 0..15 with mem_wdata = 8'hFF; then reading any address returns 8'hFF.
REQ-038 rst asserted at sweep address 7 -> SERVE and busy = 0 next cycle; addresses 8..15 keep their prior data.
REQ-039 clr_req asserted again mid-sweep -> sweep length is still 16 cycles.
